mult_fu: RTL and testbench

- Pipelined integer multiply functional unit for the RV32M MUL/MULH/MULHSU/MULHU group.
- Replaces the single-cycle "*" that was dropped from the ALU.
- Sits beside alu_fu between reservation-station issue and the CDB, and uses the same done/ack result handshake.
- Generalised over operand width, pipeline depth and tag width; adds backpressure via issue_ready, which the single-cycle ALU FU does not have.

---
 rtl/mult_fu.sv | 160 ++++++++++++++++
 tb/tb_mult_fu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu.sv
// rtl/mult_fu.sv - pipelined RV32M multiply functional unit (MUL/MULH/MULHSU/MULHU); optional squash via MULT_FU_SQUASH_EN
module mult_fu #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [XLEN-1:0]  rs1_value,
  input  logic [XLEN-1:0]  rs2_value,
  input  logic [1:0]       mul_func,
  input  logic [TAG_W-1:0] rob_tag_in,
  input  logic             ack,
`ifdef MULT_FU_SQUASH_EN
  input  logic             squash,
`endif
  output logic             done,
  output logic [XLEN-1:0]  v,
  output logic [TAG_W-1:0] rob_tag_out
);

  localparam int CHUNK = XLEN / NUM_STAGES;
  localparam int W     = 2 * XLEN;

  localparam logic [1:0] FUNC_MUL    = 2'b00;
  localparam logic [1:0] FUNC_MULH   = 2'b01;
  localparam logic [1:0] FUNC_MULHSU = 2'b10;

  // Stage registers: index k holds the operation entering stage k (k >= 1).
  // Index 0 is never loaded; stage 0 is fed straight from the issue port.
  logic             st_valid [NUM_STAGES];
  logic [1:0]       st_func  [NUM_STAGES];
  logic [TAG_W-1:0] st_tag   [NUM_STAGES];
  logic [W-1:0]     st_rs1   [NUM_STAGES];
  logic [XLEN-1:0]  st_rs2   [NUM_STAGES];
  logic             st_neg   [NUM_STAGES];
  logic [W-1:0]     st_psum  [NUM_STAGES];

  logic             src_valid [NUM_STAGES];
  logic [1:0]       src_func  [NUM_STAGES];
  logic [TAG_W-1:0] src_tag   [NUM_STAGES];
  logic [W-1:0]     src_rs1   [NUM_STAGES];
  logic [XLEN-1:0]  src_rs2   [NUM_STAGES];
  logic             src_neg   [NUM_STAGES];
  logic [W-1:0]     src_psum  [NUM_STAGES];
  logic [W-1:0]     nxt_psum  [NUM_STAGES];

  logic             rs1_signed;
  logic             rs2_signed;
  logic [W-1:0]     in_rs1;
  logic             in_neg;
  logic [W-1:0]     fin_psum;
  logic [XLEN-1:0]  fin_result;
  logic             advance;
  logic             flush;

  // Low CHUNK bits of the (pre-shifted) multiplier, zero-extended to full width.
  function automatic logic [W-1:0] zext_chunk(input logic [XLEN-1:0] x);
    zext_chunk = '0;
    zext_chunk[CHUNK-1:0] = x[CHUNK-1:0];
  endfunction

  assign rs1_signed = (mul_func == FUNC_MULH) || (mul_func == FUNC_MULHSU);
  assign rs2_signed = (mul_func == FUNC_MULH);
  assign in_rs1     = {{XLEN{rs1_signed & rs1_value[XLEN-1]}}, rs1_value};
  // rs2's sign extension is never fed through the chunks; it is folded in once at the end.
  assign in_neg     = rs2_signed & rs2_value[XLEN-1];

  // The whole pipe moves only when the output slot is free or being drained.
  assign advance     = !done || ack;
  assign issue_ready = advance;

`ifdef MULT_FU_SQUASH_EN
  assign flush = squash;
`else
  assign flush = 1'b0;
`endif

  // Select each stage's input: issue port for stage 0, stage register otherwise.
  always_comb begin
    src_valid[0] = issue_valid;
    src_func[0]  = mul_func;
    src_tag[0]   = rob_tag_in;
    src_rs1[0]   = in_rs1;
    src_rs2[0]   = rs2_value;
    src_neg[0]   = in_neg;
    src_psum[0]  = '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      src_valid[k] = st_valid[k];
      src_func[k]  = st_func[k];
      src_tag[k]   = st_tag[k];
      src_rs1[k]   = st_rs1[k];
      src_rs2[k]   = st_rs2[k];
      src_neg[k]   = st_neg[k];
      src_psum[k]  = st_psum[k];
    end
  end

  // Stage k accumulates ext_rs1 times its multiplier chunk at weight k*CHUNK.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      nxt_psum[k] = src_psum[k] + ((src_rs1[k] * zext_chunk(src_rs2[k])) << (k * CHUNK));
    end
  end

  // A negative signed rs2 has an all-ones upper half, worth -ext_rs1 << XLEN.
  assign fin_psum   = nxt_psum[NUM_STAGES-1]
                    - (src_neg[NUM_STAGES-1] ? (src_rs1[NUM_STAGES-1] << XLEN) : {W{1'b0}});
  assign fin_result = (src_func[NUM_STAGES-1] == FUNC_MUL) ? fin_psum[XLEN-1:0]
                                                           : fin_psum[W-1:XLEN];

  // Pipeline stage registers: shift as a whole on advance, clear valids on flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_valid[k] <= 1'b0;
        st_func[k]  <= '0;
        st_tag[k]   <= '0;
        st_rs1[k]   <= '0;
        st_rs2[k]   <= '0;
        st_neg[k]   <= 1'b0;
        st_psum[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_valid[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        st_valid[k] <= src_valid[k-1];
        st_func[k]  <= src_func[k-1];
        st_tag[k]   <= src_tag[k-1];
        st_rs1[k]   <= src_rs1[k-1];
        st_rs2[k]   <= src_rs2[k-1] >> CHUNK;
        st_neg[k]   <= src_neg[k-1];
        st_psum[k]  <= nxt_psum[k-1];
      end
    end
  end

  // Output slot: holds until ack, then reloads from the last stage or empties.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done        <= 1'b0;
      v           <= '0;
      rob_tag_out <= '0;
    end else if (flush) begin
      done <= 1'b0;
    end else if (advance) begin
      done <= src_valid[NUM_STAGES-1];
      if (src_valid[NUM_STAGES-1]) begin
        v           <= fin_result;
        rob_tag_out <= src_tag[NUM_STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_fu.sv
// tb/tb_mult_fu.sv - directed self-checking bench for mult_fu at NUM_STAGES 1, 4 and 8
module tb_mult_fu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rs1_value = '0;
  logic [31:0] rs2_value = '0;
  logic [1:0]  mul_func = 2'b00;
  logic [4:0]  rob_tag_in = '0;
`ifdef MULT_FU_SQUASH_EN
  logic        squash = 1'b0;
`endif

  logic        rdy1, done1, rdy4, done4, rdy8, done8;
  logic [31:0] v1, v4, v8;
  logic [4:0]  tag1, tag4, tag8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mult_fu #(.XLEN(32), .NUM_STAGES(1), .TAG_W(5)) u_dut1 (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(rdy1),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .mul_func(mul_func),
    .rob_tag_in(rob_tag_in), .ack(ack),
`ifdef MULT_FU_SQUASH_EN
    .squash(squash),
`endif
    .done(done1), .v(v1), .rob_tag_out(tag1));

  mult_fu #(.XLEN(32), .NUM_STAGES(4), .TAG_W(5)) u_dut4 (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(rdy4),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .mul_func(mul_func),
    .rob_tag_in(rob_tag_in), .ack(ack),
`ifdef MULT_FU_SQUASH_EN
    .squash(squash),
`endif
    .done(done4), .v(v4), .rob_tag_out(tag4));

  mult_fu #(.XLEN(32), .NUM_STAGES(8), .TAG_W(5)) u_dut8 (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(rdy8),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .mul_func(mul_func),
    .rob_tag_in(rob_tag_in), .ack(ack),
`ifdef MULT_FU_SQUASH_EN
    .squash(squash),
`endif
    .done(done8), .v(v8), .rob_tag_out(tag8));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    issue_valid = 1'b0;
    ack = 1'b0;
`ifdef MULT_FU_SQUASH_EN
    squash = 1'b0;
`endif
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done4 got %0b exp 0", done4); end
    checks++; if (v4 !== 32'h0) begin errors++; $display("FAIL reset_v4 got %h exp 00000000", v4); end
    checks++; if (tag4 !== 5'd0) begin errors++; $display("FAIL reset_tag4 got %0d exp 0", tag4); end
    checks++; if (done1 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL reset_done18 got %0b%0b exp 00", done1, done8); end
    reset = 1'b1;
    tick();
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", rdy4); end
  endtask

  task automatic test_funcs();
    logic [1:0]  f [8];
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [31:0] e [8];
    f[0] = 2'b01; a[0] = 32'h80000000; b[0] = 32'h80000000; e[0] = 32'h40000000;
    f[1] = 2'b10; a[1] = 32'hFFFFFFFF; b[1] = 32'hFFFFFFFF; e[1] = 32'hFFFFFFFF;
    f[2] = 2'b11; a[2] = 32'hFFFFFFFF; b[2] = 32'hFFFFFFFF; e[2] = 32'hFFFFFFFE;
    f[3] = 2'b00; a[3] = 32'hFFFFFFFF; b[3] = 32'hFFFFFFFF; e[3] = 32'h00000001;
    f[4] = 2'b00; a[4] = 32'hFFFFFFFD; b[4] = 32'h00000005; e[4] = 32'hFFFFFFF1;
    f[5] = 2'b01; a[5] = 32'hFFFFFFFD; b[5] = 32'h00000005; e[5] = 32'hFFFFFFFF;
    f[6] = 2'b11; a[6] = 32'h80000000; b[6] = 32'h00000002; e[6] = 32'h00000001;
    f[7] = 2'b10; a[7] = 32'h00000002; b[7] = 32'hFFFFFFFF; e[7] = 32'h00000001;
    apply_reset();
    ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mul_func = f[i];
      rs1_value = a[i];
      rs2_value = b[i];
      rob_tag_in = 5'(i + 8);
      issue_valid = 1'b1;
      for (int c = 1; c <= 9; c++) begin
        tick();
        issue_valid = 1'b0;
        if (c == 1) begin
          checks++; if (done1 !== 1'b1 || v1 !== e[i]) begin errors++; $display("FAIL func%0d_n1 got done=%0b v=%h exp done=1 v=%h", i, done1, v1, e[i]); end
        end
        if (c == 3) begin
          checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL func%0d_n4_early got done=%0b exp 0", i, done4); end
        end
        if (c == 4) begin
          checks++; if (done4 !== 1'b1 || v4 !== e[i] || tag4 !== 5'(i + 8)) begin errors++; $display("FAIL func%0d_n4 got done=%0b v=%h tag=%0d exp done=1 v=%h tag=%0d", i, done4, v4, tag4, e[i], i + 8); end
        end
        if (c == 5) begin
          checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL func%0d_n4_clear got done=%0b exp 0", i, done4); end
        end
        if (c == 8) begin
          checks++; if (done8 !== 1'b1 || v8 !== e[i]) begin errors++; $display("FAIL func%0d_n8 got done=%0b v=%h exp done=1 v=%h", i, done8, v8, e[i]); end
        end
      end
    end
  endtask

  task automatic test_mul_basic();
    apply_reset();
    ack = 1'b1;
    mul_func = 2'b00; rs1_value = 32'd7; rs2_value = 32'd6; rob_tag_in = 5'd3;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    repeat (3) tick();
    checks++; if (done4 !== 1'b1 || v4 !== 32'd42 || tag4 !== 5'd3) begin errors++; $display("FAIL mul_basic got done=%0b v=%0d tag=%0d exp done=1 v=42 tag=3", done4, v4, tag4); end
    tick();
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL mul_basic_clear got done=%0b exp 0", done4); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ack = 1'b0;
    mul_func = 2'b00;
    rs2_value = 32'd10;
    for (int t = 1; t <= 4; t++) begin
      rs1_value = 32'(t);
      rob_tag_in = 5'(t);
      issue_valid = 1'b1;
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (done4 !== 1'b1 || tag4 !== 5'd1 || v4 !== 32'd10) begin errors++; $display("FAIL b2b_first got done=%0b tag=%0d v=%0d exp 1/1/10", done4, tag4, v4); end
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got %0b exp 0", rdy4); end
    // Offered while stalled: must never be captured.
    issue_valid = 1'b1; rob_tag_in = 5'd7; rs1_value = 32'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (done4 !== 1'b1 || tag4 !== 5'd1 || v4 !== 32'd10) begin errors++; $display("FAIL b2b_hold%0d got done=%0b tag=%0d v=%0d exp 1/1/10", c, done4, tag4, v4); end
    end
    issue_valid = 1'b0;
    ack = 1'b1;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL b2b_ready_comb got %0b exp 1", rdy4); end
    for (int t = 2; t <= 4; t++) begin
      tick();
      checks++; if (done4 !== 1'b1 || tag4 !== 5'(t) || v4 !== 32'(10 * t)) begin errors++; $display("FAIL b2b_tag%0d got done=%0b tag=%0d v=%0d exp 1/%0d/%0d", t, done4, tag4, v4, t, 10 * t); end
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL b2b_drain%0d got done=%0b tag=%0d exp done=0", c, done4, tag4); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ack = 1'b0;
    mul_func = 2'b00; rs1_value = 32'd3; rs2_value = 32'd3;
    for (int t = 1; t <= 4; t++) begin
      rob_tag_in = 5'(t);
      issue_valid = 1'b1;
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (done4 !== 1'b1 || v4 !== 32'd9) begin errors++; $display("FAIL rmid_pre got done=%0b v=%0d exp 1/9", done4, v4); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (done4 !== 1'b0 || v4 !== 32'd0 || tag4 !== 5'd0) begin errors++; $display("FAIL rmid_async got done=%0b v=%0d tag=%0d exp 0/0/0", done4, v4, tag4); end
    tick();
    reset = 1'b1;
    ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d got done=%0b tag=%0d exp done=0", c, done4, tag4); end
    end
  endtask

`ifdef MULT_FU_SQUASH_EN
  task automatic test_squash();
    apply_reset();
    ack = 1'b1;
    mul_func = 2'b00; rs1_value = 32'd2; rs2_value = 32'd2;
    rob_tag_in = 5'd1; issue_valid = 1'b1;
    tick();
    rob_tag_in = 5'd2;
    tick();
    rob_tag_in = 5'd5; squash = 1'b1;
    tick();
    squash = 1'b0;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL squash_ready got %0b exp 1", rdy4); end
    rob_tag_in = 5'd9; rs1_value = 32'd4; rs2_value = 32'd5;
    tick();
    issue_valid = 1'b0;
    for (int c = 5; c <= 13; c++) begin
      tick();
      if (c == 7) begin
        checks++; if (done4 !== 1'b1 || tag4 !== 5'd9 || v4 !== 32'd20) begin errors++; $display("FAIL squash_new got done=%0b tag=%0d v=%0d exp 1/9/20", done4, tag4, v4); end
      end else begin
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL squash_quiet%0d got done=%0b tag=%0d exp done=0", c, done4, tag4); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mul_basic();
    test_funcs();
    test_back_to_back();
    test_reset_mid();
`ifdef MULT_FU_SQUASH_EN
    test_squash();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
